alt_ddr_input_deser: RTL and testbench

Parametrised DDR input deserialiser with word alignment. It captures a PAD_WIDTH-bit DDR pad bus on both edges of inclock and assembles RATIO consecutive beats into one word. It then slides the word boundary beat-by-beat until a programmable sync word is seen LOCK_COUNT times in a row. It sits directly behind the pad ring on source-synchronous line/backplane inputs, feeding framers that need parallel, word-aligned data.

---
 rtl/alt_ddr_pkg.sv | 18 +
 rtl/alt_ddr_capture_r.sv | 40 ++++
 rtl/alt_ddr_input_deser.sv | 165 ++++++++++++++++
 tb/tb_alt_ddr_input_deser.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alt_ddr_pkg.sv
// Shared definitions for the DDR input deserialiser.
//   state_e   : alignment FSM states (IDLE, SEARCH, LOCKED)
//   OFS_W     : width of the beat offset (slip_offset)
//   RATIO_MAX : largest supported beats-per-word ratio
//   SLIP_SAT  : saturation value of the slip counter
package alt_ddr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int         OFS_W     = 3;
  localparam int         RATIO_MAX = 8;
  localparam logic [7:0] SLIP_SAT  = 8'hFF;

endpackage

// File: rtl/alt_ddr_capture_r.sv
// Single-bit DDR capture cell.
//   clk_i   : capture clock, both edges used
//   rst_n_i : asynchronous active-low reset
//   d_i     : pad bit
//   l_o     : beat sampled on the falling edge, retimed to the rising edge
//   h_o     : beat sampled on the rising edge
// Within one rising-edge cycle, l_o is chronologically older than h_o.
module alt_ddr_capture_r
  import alt_ddr_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic l_o,
  output logic h_o
);

  logic l_neg_q;
  logic l_q;
  logic h_q;

  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) l_neg_q <= 1'b0;
    else          l_neg_q <= d_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      l_q <= 1'b0;
      h_q <= 1'b0;
    end else begin
      l_q <= l_neg_q;
      h_q <= d_i;
    end
  end

  assign l_o = l_q;
  assign h_o = h_q;

endmodule

// File: rtl/alt_ddr_input_deser.sv
// DDR input deserialiser with word alignment.
// Captures a PAD_WIDTH-bit DDR bus on both clock edges, assembles RATIO
// beats per word, and slides the word boundary one beat per mismatch until
// sync_word is matched LOCK_COUNT boundaries in a row.
// Ports:
//   inclock     : capture/system clock
//   rstn        : asynchronous active-low reset
//   datain      : DDR pad data
//   align_req   : one-cycle pulse, (re)start alignment
//   sync_word   : alignment pattern, first beat in LSB slice
//   dataout     : aligned word, first beat in LSB slice
//   dataout_vld : one-cycle strobe per word while locked
//   locked      : alignment achieved
//   slip_offset : current beat offset
//   slip_cnt    : saturating slip counter
//   dbg_state   : FSM state (state_e encoding)
// Build option: ALT_DDR_DESER_SLIP_CNT_EN builds the slip counter; without
// it slip_cnt reads 0.
// Handshake: dataout is meaningful only in the cycle dataout_vld is high;
// there is no back-pressure.
module alt_ddr_input_deser
  import alt_ddr_pkg::*;
#(
  parameter int PAD_WIDTH  = 8,
  parameter int RATIO      = 4,
  parameter int LOCK_COUNT = 4
) (
  input  logic                         inclock,
  input  logic                         rstn,
  input  logic [PAD_WIDTH-1:0]         datain,
  input  logic                         align_req,
  input  logic [PAD_WIDTH*RATIO-1:0]   sync_word,
  output logic [PAD_WIDTH*RATIO-1:0]   dataout,
  output logic                         dataout_vld,
  output logic                         locked,
  output logic [2:0]                   slip_offset,
  output logic [7:0]                   slip_cnt,
  output logic [1:0]                   dbg_state
);

  localparam int WW   = PAD_WIDTH * RATIO;
  localparam int HW   = 2 * WW;
  localparam int HALF = RATIO / 2;
  localparam int PH_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [PAD_WIDTH-1:0] beat_l;
  logic [PAD_WIDTH-1:0] beat_h;

  for (genvar g = 0; g < PAD_WIDTH; g++) begin : g_cap
    alt_ddr_capture_r u_cap (
      .clk_i   (inclock),
      .rst_n_i (rstn),
      .d_i     (datain[g]),
      .l_o     (beat_l[g]),
      .h_o     (beat_h[g])
    );
  end

  // History: slice 2*RATIO-1 is the newest beat, slice 0 the oldest.
  logic [HW-1:0] hist_q;
  logic [HW-1:0] hist_d;
  assign hist_d = {beat_h, beat_l, hist_q[HW-1:2*PAD_WIDTH]};

  logic [PH_W-1:0] phase_q;
  logic            boundary;
  assign boundary = (phase_q == PH_W'(HALF - 1));

  always_ff @(posedge inclock or negedge rstn) begin
    if (!rstn) begin
      hist_q  <= '0;
      phase_q <= '0;
    end else begin
      hist_q  <= hist_d;
      phase_q <= boundary ? '0 : phase_q + PH_W'(1);
    end
  end

  // Candidate word: the upper half of history (newest RATIO beats) at
  // offset 0; each offset step moves the window one beat older.
  state_e           state_q;
  logic [OFS_W-1:0] ofs_q;
  logic [3:0]       match_q;
  logic [WW-1:0]    cand;
  logic             cand_match;
  logic [OFS_W-1:0] ofs_next;

  always_comb begin
    cand = hist_q[WW +: WW];
    for (int k = 1; k < RATIO; k++) begin
      if (ofs_q == OFS_W'(k)) cand = hist_q[(RATIO - k) * PAD_WIDTH +: WW];
    end
  end

  assign cand_match = (cand == sync_word);
  assign ofs_next   = (ofs_q == OFS_W'(RATIO - 1)) ? '0 : ofs_q + OFS_W'(1);

  logic [WW-1:0] dout_q;
  logic          vld_q;
  logic          locked_q;

  always_ff @(posedge inclock or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      ofs_q    <= '0;
      match_q  <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      // align_req takes priority over any compare in the same cycle.
      if (align_req) begin
        state_q  <= ST_SEARCH;
        ofs_q    <= '0;
        match_q  <= '0;
        locked_q <= 1'b0;
      end else if (boundary) begin
        case (state_q)
          ST_SEARCH: begin
            if (cand_match) begin
              if (match_q == 4'(LOCK_COUNT - 1)) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
                dout_q   <= cand;
                vld_q    <= 1'b1;
              end
              match_q <= match_q + 4'd1;
            end else begin
              match_q <= '0;
              ofs_q   <= ofs_next;
            end
          end
          ST_LOCKED: begin
            dout_q <= cand;
            vld_q  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ALT_DDR_DESER_SLIP_CNT_EN
  logic [7:0] slip_q;
  logic       slip_evt;
  assign slip_evt = (state_q == ST_SEARCH) && boundary && !align_req && !cand_match;

  always_ff @(posedge inclock or negedge rstn) begin
    if (!rstn)                              slip_q <= '0;
    else if (align_req)                     slip_q <= '0;
    else if (slip_evt && slip_q != SLIP_SAT) slip_q <= slip_q + 8'd1;
  end

  assign slip_cnt = slip_q;
`else
  assign slip_cnt = 8'd0;
`endif

  assign dataout     = dout_q;
  assign dataout_vld = vld_q;
  assign locked      = locked_q;
  assign slip_offset = ofs_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alt_ddr_input_deser.sv
// Testbench for alt_ddr_input_deser (PAD_WIDTH=8, RATIO=4, LOCK_COUNT=4).
// A beat-queue model predicts every output on every cycle; literal checks
// pin lock offsets, slip counts and reset behaviour.
module tb_alt_ddr_input_deser;

  localparam int W    = 8;
  localparam int R    = 4;
  localparam int LC   = 4;
  localparam int HALF = R / 2;
  localparam int S_IDLE = 0, S_SEARCH = 1, S_LOCKED = 2;

  // ---------------- clock / reset ----------------
  logic           inclock = 1'b0;
  logic           rstn = 1'b0;
  logic [W-1:0]   datain = '0;
  logic           align_req = 1'b0;
  logic [W*R-1:0] sync_word = 32'hA1B2C3D4;
  logic [W*R-1:0] dataout;
  logic           dataout_vld;
  logic           locked;
  logic [2:0]     slip_offset;
  logic [7:0]     slip_cnt;
  logic [1:0]     dbg_state;

  always #5 inclock = ~inclock;

  alt_ddr_input_deser #(.PAD_WIDTH(W), .RATIO(R), .LOCK_COUNT(LC)) dut (
    .inclock     (inclock),
    .rstn        (rstn),
    .datain      (datain),
    .align_req   (align_req),
    .sync_word   (sync_word),
    .dataout     (dataout),
    .dataout_vld (dataout_vld),
    .locked      (locked),
    .slip_offset (slip_offset),
    .slip_cnt    (slip_cnt),
    .dbg_state   (dbg_state)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

`ifdef ALT_DDR_DESER_SLIP_CNT_EN
  localparam bit SLIP_EN = 1'b1;
`else
  localparam bit SLIP_EN = 1'b0;
`endif

  // ---------------- beat driver ----------------
  // mode 0: repeating sync_word beats rotated by skew; 1: constant 00; 2: random
  int mode = 0;
  int skew = 0;
  int bc   = 0;

  function automatic logic [W-1:0] beat_val(input int q);
    logic [W-1:0] v;
    case (mode)
      0:       v = sync_word[((q + skew) % R) * W +: W];
      1:       v = 8'h00;
      default: v = W'($urandom_range(0, 255));
    endcase
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge inclock); #1;
      if (!rstn) bc = 0;
      datain = beat_val(bc); bc++;
      @(negedge inclock); #1;
      datain = beat_val(bc); bc++;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // beats[] holds every beat the DUT has captured, oldest first, prefixed
  // by zeros for the reset contents of the capture stage and history.
  logic [W-1:0]   beats[$];
  logic [W-1:0]   l_smp = '0;
  int             kk, m_off, m_match, m_slip, m_state;
  bit             m_vld, m_locked;
  logic [W*R-1:0] m_dout;

  task automatic m_reset();
    beats.delete();
    for (int i = 0; i < 2 * R + 2; i++) beats.push_back('0);
    kk = 0; m_off = 0; m_match = 0; m_slip = 0; m_state = S_IDLE;
    m_vld = 0; m_locked = 0; m_dout = '0;
  endtask

  task automatic model_edge();
    logic [W*R-1:0] cand;
    int n;
    bit bnd;
    kk++;
    bnd = ((kk - 1) % HALF) == (HALF - 1);
    n = beats.size();
    // Word visible at this edge ends two beats (capture stage) behind the
    // newest beat; each offset step reaches one beat further back.
    for (int i = 0; i < R; i++) cand[i*W +: W] = beats[n - 2 - R - m_off + i];
    m_vld = 0;
    if (align_req) begin
      m_state = S_SEARCH; m_off = 0; m_match = 0; m_slip = 0; m_locked = 0;
    end else if (bnd && m_state == S_SEARCH) begin
      if (cand == sync_word) begin
        m_match++;
        if (m_match == LC) begin
          m_state = S_LOCKED; m_locked = 1; m_vld = 1; m_dout = cand;
        end
      end else begin
        m_match = 0;
        m_off = (m_off + 1) % R;
        if (SLIP_EN && m_slip < 255) m_slip++;
      end
    end else if (bnd && m_state == S_LOCKED) begin
      m_dout = cand; m_vld = 1;
    end
    beats.push_back(l_smp);
    beats.push_back(datain);
    while (beats.size() > 32) void'(beats.pop_front());
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge inclock);
      if (!rstn) m_reset();
      else       model_edge();
      @(negedge inclock);
      if (!rstn) m_reset();
      chk("dataout",     dataout,     m_dout);
      chk("dataout_vld", dataout_vld, m_vld);
      chk("locked",      locked,      m_locked);
      chk("slip_offset", slip_offset, m_off);
      chk("slip_cnt",    slip_cnt,    m_slip);
      chk("state",       dbg_state,   m_state);
      l_smp = rstn ? datain : '0;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic pulse_align();
    @(posedge inclock); #1 align_req = 1'b1;
    @(posedge inclock); #1 align_req = 1'b0;
    @(negedge inclock);
    chk("align_locked", locked, 0);
    chk("align_vld", dataout_vld, 0);
    chk("align_offset", slip_offset, 0);
    chk("align_slip", slip_cnt, 0);
    chk("align_state", dbg_state, S_SEARCH);
  endtask

  task automatic wait_lock(input int budget);
    int c;
    c = 0;
    while (!locked && c < budget) begin
      @(negedge inclock);
      c++;
    end
    n_chk++;
    if (!locked) begin
      n_err++;
      $display("FAIL lock_timeout locked=%0b required=1 within %0d cycles", locked, budget);
    end
  endtask

  task automatic lock_case(input int d);
    int nv;
    mode = 0; skew = d;
    repeat (6) @(negedge inclock);
    pulse_align();
    wait_lock(40);
    chk("lock_offset", slip_offset, d);
    chk("lock_slips", slip_cnt, SLIP_EN ? d : 0);
    chk("lock_word", dataout, 32'hA1B2C3D4);
    chk("lock_vld_first", dataout_vld, 1);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge inclock);
      if (dataout_vld) nv++;
    end
    chk("vld_rate", nv, 4);
    chk("locked_word_hold", dataout, 32'hA1B2C3D4);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #3;
    chk("rst_dataout", dataout, 0);
    chk("rst_vld", dataout_vld, 0);
    chk("rst_locked", locked, 0);
    chk("rst_state", dbg_state, S_IDLE);
    repeat (3) @(posedge inclock);
    #2 rstn = 1'b1;
    repeat (10) @(negedge inclock);
    chk("idle_state", dbg_state, S_IDLE);

    lock_case(0);
    lock_case(1);
    lock_case(3);

    // no sync word at all: slips forever, counter saturates
    mode = 1;
    pulse_align();
    repeat (600) @(negedge inclock);
    chk("sat_locked", locked, 0);
    chk("sat_slip", slip_cnt, SLIP_EN ? 255 : 0);

    // randomized stream kinds, skews and align timing
    for (int it = 0; it < 8; it++) begin
      mode = ($urandom_range(0, 2) == 2) ? 2 : 0;
      skew = $urandom_range(0, R - 1);
      repeat ($urandom_range(0, 7)) @(negedge inclock);
      pulse_align();
      repeat ($urandom_range(10, 50)) @(negedge inclock);
    end

    // asynchronous reset in the middle of a search
    mode = 1;
    pulse_align();
    repeat (5) @(negedge inclock);
    @(posedge inclock); #3 rstn = 1'b0;
    #1;
    chk("mid_rst_dataout", dataout, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_offset", slip_offset, 0);
    chk("mid_rst_slip", slip_cnt, 0);
    chk("mid_rst_state", dbg_state, S_IDLE);
    repeat (3) @(posedge inclock);
    #2 rstn = 1'b1;
    repeat (10) @(negedge inclock);
    chk("post_rst_state", dbg_state, S_IDLE);
    chk("post_rst_offset", slip_offset, 0);

    lock_case(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
